countdown_timer: RTL and testbench

- Minute/second countdown timer: the decrementing counterpart of the clock's up-counting minute chain.
- Consumes the same 1 Hz sec_tic strobe used by the clock generators.
- Counts a loaded MM:SS value down to 00:00, generating a borrow strobe at each minute boundary and a one-cycle done strobe at expiry.
- Sits beside the clock chain and drives the display mux and buzzer logic in timer mode.

---
 rtl/countdown_timer.sv | 133 +++++++++++++
 tb/tb_countdown_timer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by the shared 1 Hz sec_tic strobe.
// Counts a clamped preset down to 00:00, flags minute borrows and a one-cycle expiry strobe.
module countdown_timer #(
  parameter int P_MIN_BIT = 6,
  parameter int P_SEC_BIT = 6,
  parameter int P_MAX_MIN = 59
) (
  input  logic                 clk,
  input  logic                 reset_all,
  input  logic                 sec_tic,
  input  logic                 load,
  input  logic [P_MIN_BIT-1:0] load_min,
  input  logic [P_SEC_BIT-1:0] load_sec,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 clear,
  output logic [P_MIN_BIT-1:0] min,
  output logic [P_SEC_BIT-1:0] sec,
  output logic                 running,
  output logic                 paused,
  output logic                 expired,
  output logic                 done_tic,
  output logic                 min_borrow_tic
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [P_MIN_BIT-1:0] MAX_MIN = P_MIN_BIT'(P_MAX_MIN);
  localparam logic [P_SEC_BIT-1:0] MAX_SEC = P_SEC_BIT'(59);

  state_e               state_q, state_d;
  logic [P_MIN_BIT-1:0] min_q, min_d;
  logic [P_SEC_BIT-1:0] sec_q, sec_d;
  logic                 run_q, pau_q, exp_q, done_q;

  logic [P_MIN_BIT-1:0] ld_min_c;
  logic [P_SEC_BIT-1:0] ld_sec_c;
  logic                 ld_zero;

  assign ld_min_c = (load_min > MAX_MIN) ? MAX_MIN : load_min;
  assign ld_sec_c = (load_sec > MAX_SEC) ? MAX_SEC : load_sec;
  assign ld_zero  = (ld_min_c == '0) && (ld_sec_c == '0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (clear) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load) begin
            min_d   = ld_min_c;
            sec_d   = ld_sec_c;
            state_d = ld_zero ? S_IDLE : S_READY;
          end
        end
        S_READY, S_PAUSED: begin
          if (load) begin
            min_d   = ld_min_c;
            sec_d   = ld_sec_c;
            state_d = ld_zero ? S_IDLE : S_READY;
          end else if (start) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (sec_tic) begin
            // A zero count is never decremented; it can only mean expiry.
            if (min_q == '0 && sec_q == '0) begin
              state_d = S_DONE;
            end else begin
              if (sec_q != '0) begin
                sec_d = sec_q - 1'b1;
              end else begin
                sec_d = MAX_SEC;
                min_d = min_q - 1'b1;
              end
              if (min_q == '0 && sec_q == P_SEC_BIT'(1)) state_d = S_DONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          min_d   = '0;
          sec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      run_q   <= 1'b0;
      pau_q   <= 1'b0;
      exp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      run_q   <= (state_d == S_RUN);
      pau_q   <= (state_d == S_PAUSED);
      exp_q   <= (state_d == S_DONE);
      done_q  <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign min      = min_q;
  assign sec      = sec_q;
  assign running  = run_q;
  assign paused   = pau_q;
  assign expired  = exp_q;
  assign done_tic = done_q;

  assign min_borrow_tic = (state_q == S_RUN) & sec_tic & (sec_q == '0) & (min_q != '0)
                        & ~pause & ~clear & ~reset_all;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus random stimulus for countdown_timer, checked against a
// remaining-seconds model of the timer.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_all = 1'b0, sec_tic = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [5:0] load_min = '0, load_sec = '0;
  logic [5:0] min, sec;
  logic       running, paused, expired, done_tic, min_borrow_tic;

  int errors = 0;
  int checks = 0;

  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;
  int m_rem = 0;
  int m_st  = M_IDLE;
  bit m_done = 0;

  always #5 clk = ~clk;

  countdown_timer #(.P_MIN_BIT(6), .P_SEC_BIT(6), .P_MAX_MIN(59)) dut (
    .clk(clk), .reset_all(reset_all), .sec_tic(sec_tic), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .clear(clear), .min(min), .sec(sec), .running(running), .paused(paused),
    .expired(expired), .done_tic(done_tic), .min_borrow_tic(min_borrow_tic)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit l, input int lm, input int ls,
                      input bit p, input bit s, input bit t);
    int mm, ss;
    bit exp_borrow;
    @(negedge clk);
    reset_all = r; clear = c; load = l; load_min = 6'(lm); load_sec = 6'(ls);
    pause = p; start = s; sec_tic = t;
    #1;
    exp_borrow = (m_st == M_RUN) && t && !p && !c && !r && (m_rem >= 60) && (m_rem % 60 == 0);
    chk("borrow", {31'd0, min_borrow_tic}, {31'd0, exp_borrow});
    @(posedge clk);
    m_done = 0;
    if (r || c) begin
      m_st = M_IDLE; m_rem = 0;
    end else if (l && m_st != M_RUN) begin
      mm = (lm > 59) ? 59 : lm;
      ss = (ls > 59) ? 59 : ls;
      m_rem = mm * 60 + ss;
      m_st = (m_rem != 0) ? M_READY : M_IDLE;
    end else if (p && m_st == M_RUN) begin
      m_st = M_PAUSED;
    end else if (s && (m_st == M_READY || m_st == M_PAUSED)) begin
      m_st = M_RUN;
    end else if (t && m_st == M_RUN) begin
      m_rem--;
      if (m_rem == 0) begin m_st = M_DONE; m_done = 1; end
    end
    #1;
    chk("min",      {26'd0, min},      32'(m_rem / 60));
    chk("sec",      {26'd0, sec},      32'(m_rem % 60));
    chk("running",  {31'd0, running},  {31'd0, m_st == M_RUN});
    chk("paused",   {31'd0, paused},   {31'd0, m_st == M_PAUSED});
    chk("expired",  {31'd0, expired},  {31'd0, m_st == M_DONE});
    chk("done_tic", {31'd0, done_tic}, {31'd0, m_done});
  endtask

  task automatic tic();   step(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic go();    step(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic ld(input int lm, input int ls); step(0, 0, 1, lm, ls, 0, 0, 0); endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-run
    ld(2, 30); go();
    repeat (5) tic();
    step(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tic();

    // Basic countdown with expiry and post-expiry tics
    ld(0, 3); go();
    repeat (3) tic();
    repeat (2) tic();
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Minute borrow then run to DONE
    ld(2, 0); go();
    tic();
    repeat (119) tic();

    // Clamp, empty load, start ignored in IDLE
    ld(63, 60);
    ld(0, 0);
    go();

    // Pause coincident with tic, ignored tics, resume with borrow
    ld(1, 0); go();
    step(0, 0, 0, 0, 0, 1, 0, 1);
    repeat (3) tic();
    go();
    tic();

    // Priority: load ignored in RUN, pause beats start, clear beats tic
    ld(0, 10); go();
    step(0, 0, 1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    go();
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 3, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, c, l, p, s, t;
      int lm, ls;
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 29) == 0);
      lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      ls = int'($urandom_range(0, 63));
      p  = ($urandom_range(0, 24) == 0);
      s  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 2) == 0);
      step(r, c, l, lm, ls, p, s, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
